vga_timing_gen: RTL
===================

# vga_timing_gen

- Parametrised VGA raster engine that replaces the fixed 640x480 controller inside the VGA top level.
- Generates horizontal/vertical timing from parameters and issues pixel coordinates to the picture generator.
- Delays sync and data-enable by a configurable pixel-pipeline latency so they line up with the returned `pix_data`.
- Latches the display mode once per frame so panels never switch mid-frame. Sits between the clock wizard and `vga_pic`.

## Interface

Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, hsync active level
- `VS_POL`, 0, vsync active level
- `PIX_LAT`, 2, cycles from `pos_x`/`pos_y` to valid `pix_data`; legal range 1..4
- `POS_W`, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- `COLOR_W`, 24, RGB width
- `MODE_W`, 8, mode word width

Ports:
- `vga_clk`, in, 1, pixel clock; the only clock
- `sys_rst`, in, 1, synchronous, active-high reset
- `enable`, in, 1, raster run request
- `mode_in`, in, MODE_W, requested display mode
- `pix_data`, in, COLOR_W, pixel colour from the picture generator
- `pos_x`, out, POS_W, requested pixel column
- `pos_y`, out, POS_W, requested pixel row
- `pos_valid`, out, 1, request is inside the active area
- `mode_frame`, out, MODE_W, mode in force for the current frame
- `line_start`, out, 1, one-cycle pulse at h_cnt==0
- `frame_start`, out, 1, one-cycle pulse at (0,0)
- `frame_cnt`, out, 16, completed-frame counter
- `hsync`, out, 1, horizontal sync
- `vsync`, out, 1, vertical sync
- `de`, out, 1, display enable, aligned to `rgb`
- `rgb`, out, COLOR_W, output colour; zero when `de`=0

## Operation

- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL is defined the same way from the vertical parameters.
- `running` flag:
  - Cleared by `sys_rst` or by `enable`=0.
  - Set on the cycle after `enable` is sampled 1.
  - `enable`=0 mid-frame aborts the frame: counters return to (0,0) and the delay taps are loaded with inactive values.
- Counters:
  - `h_cnt` and `v_cnt` advance only while `running`.
  - `h_cnt` wraps at H_TOTAL-1. `v_cnt` increments on each `h_cnt` wrap and itself wraps at V_TOTAL-1.
  - The first running cycle is (0,0).
- Request stage (combinational from the counters, gated by `running`):
  - `pos_valid` = running & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE.
  - `pos_x`/`pos_y` equal the counters when `pos_valid`=1, else 0.
- Raw stage signals:
  - Sync is active while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vertical is analogous.
  - Each raw signal passes through a PIX_LAT-deep shift register.
- Output register:
  - `hsync`, `vsync`, `de` are the last tap, registered.
  - `rgb` <= de_tap ? `pix_data` : 0.
- Pulses and counters:
  - `line_start` and `frame_start` are request-stage pulses, gated by `running`.
  - `frame_cnt` increments when the counters wrap (H_TOTAL-1, V_TOTAL-1) and wraps 16'hFFFF->0.
- Mode shadow:
  - `mode_frame` <= `mode_in` at the cycle where h_cnt==H_TOTAL-1 and v_cnt==V_ACTIVE-1, i.e. at the start of vertical blanking.
  - A `mode_in` change during the active area takes effect only from the next frame's active area.

## Timing

- Reset (`sys_rst`=1, takes effect on the next `vga_clk` edge), all outputs forced to:
  - `hsync`=~HS_POL, `vsync`=~VS_POL
  - `de`=0, `rgb`=0
  - `pos_valid`=0, `pos_x`=`pos_y`=0
  - `line_start`=`frame_start`=0
  - `frame_cnt`=0, `mode_frame`=0
  - h_cnt=v_cnt=0, running=0
- Reset mid-frame: same as the reset values above; there is no partial-frame flush.
- Latency:
  - `pix_data` is sampled PIX_LAT cycles after the matching `pos_x` is presented.
  - `hsync`/`vsync`/`de`/`rgb` appear PIX_LAT+1 cycles after the counter state that produced them.
- Simultaneous events:
  - At the end-of-frame wrap, the `frame_cnt` increment and `frame_start` (0,0) of the next frame occur on consecutive cycles.
  - Reset overrides `enable`.

## Test plan

Small parameter set for all scenarios:
- H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=2 (H_TOTAL=15)
- V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8)
- PIX_LAT=2, HS_POL=VS_POL=0

Scenarios:
- **Reset:** hold `sys_rst` for 3 cycles with `enable`=1 -> `hsync`=`vsync`=1, `de`=0, `rgb`=0, `frame_cnt`=0. The first `frame_start` occurs 2 cycles after reset release.
- **Geometry:** run 2 frames -> each line has 8 `pos_valid` cycles and each frame 120 cycles.
  - `hsync` is low for 3 cycles, starting 3 cycles after h_cnt=10.
  - `vsync` is low during lines 5-6, delayed by 3 cycles.
- **Alignment:** model `pix_data` = {pos_y,pos_x} delayed 2 cycles -> each `rgb` during `de` equals its coordinate pair. `rgb`=0 whenever `de`=0.
- **Mode shadow:** change `mode_in` 8'h01->8'h02 at v_cnt=1 -> `mode_frame` switches exactly at (14,3) and is constant across the whole active area of every frame.
- **Enable abort:** drop `enable` at (5,2) for 1 cycle -> outputs go inactive, the next frame restarts at (0,0), and `frame_cnt` is unchanged.
- **Wrap:** preload 65535 completed frames (force or long run) -> `frame_cnt` rolls over to 0 on the next frame wrap.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : Parametrised VGA raster engine. Generates pixel requests for the
//             picture generator, delays sync/data-enable to match the pixel
//             pipeline latency, and shadows the display mode once per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 2,
  parameter int POS_W    = 10,
  parameter int COLOR_W  = 24,
  parameter int MODE_W   = 8
) (
  input  logic               vga_clk,
  input  logic               sys_rst,
  input  logic               enable,
  input  logic [MODE_W-1:0]  mode_in,
  input  logic [COLOR_W-1:0] pix_data,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y,
  output logic               pos_valid,
  output logic [MODE_W-1:0]  mode_frame,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_cnt,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width copies of the geometry so every compare is width-matched.
  localparam logic [POS_W-1:0] C_ONE        = POS_W'(1);
  localparam logic [POS_W-1:0] C_H_LAST     = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] C_V_LAST     = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] C_H_ACT      = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] C_V_ACT      = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] C_V_ACT_LAST = POS_W'(V_ACTIVE - 1);
  localparam logic [POS_W-1:0] C_HS_BEG     = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] C_HS_END     = POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [POS_W-1:0] C_VS_BEG     = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] C_VS_END     = POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic               running;
  logic [POS_W-1:0]   h_cnt;
  logic [POS_W-1:0]   v_cnt;
  logic               h_last;
  logic               v_last;
  logic               advance;
  logic               hs_raw;
  logic               vs_raw;
  logic               de_raw;
  logic [PIX_LAT-1:0] hs_tap;
  logic [PIX_LAT-1:0] vs_tap;
  logic [PIX_LAT-1:0] de_tap;

  // Wrap detection and the qualified "count this cycle" strobe; a cycle in
  // which enable has already dropped is treated as aborted, not counted.
  always_comb begin
    h_last  = (h_cnt == C_H_LAST);
    v_last  = (v_cnt == C_V_LAST);
    advance = running && enable;
  end

  // Run flag follows enable one cycle later; reset dominates.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      running <= 1'b0;
    end else begin
      running <= enable;
    end
  end

  // Raster counters; held at (0,0) whenever the raster is stopped or aborted.
  always_ff @(posedge vga_clk) begin
    if (sys_rst || !advance) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : (v_cnt + C_ONE);
    end else begin
      h_cnt <= h_cnt + C_ONE;
    end
  end

  // Request stage and raw (undelayed) timing flags, all gated by running.
  always_comb begin
    pos_valid   = running && (h_cnt < C_H_ACT) && (v_cnt < C_V_ACT);
    pos_x       = pos_valid ? h_cnt : '0;
    pos_y       = pos_valid ? v_cnt : '0;
    line_start  = running && (h_cnt == '0);
    frame_start = line_start && (v_cnt == '0);
    hs_raw      = running && (h_cnt >= C_HS_BEG) && (h_cnt <= C_HS_END);
    vs_raw      = running && (v_cnt >= C_VS_BEG) && (v_cnt <= C_VS_END);
    de_raw      = pos_valid;
  end

  // PIX_LAT-deep delay lines (bit 0 newest); flushed to inactive on abort.
  always_ff @(posedge vga_clk) begin
    if (sys_rst || !enable) begin
      hs_tap <= '0;
      vs_tap <= '0;
      de_tap <= '0;
    end else begin
      hs_tap <= PIX_LAT'({hs_tap, hs_raw});
      vs_tap <= PIX_LAT'({vs_tap, vs_raw});
      de_tap <= PIX_LAT'({de_tap, de_raw});
    end
  end

  // Output register: apply sync polarity and blank colour outside de.
  always_ff @(posedge vga_clk) begin
    if (sys_rst || !enable) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b0;
      rgb   <= '0;
    end else begin
      hsync <= hs_tap[PIX_LAT-1] ? HS_POL : ~HS_POL;
      vsync <= vs_tap[PIX_LAT-1] ? VS_POL : ~VS_POL;
      de    <= de_tap[PIX_LAT-1];
      rgb   <= de_tap[PIX_LAT-1] ? pix_data : '0;
    end
  end

  // Completed-frame counter and per-frame mode shadow (latched at the start
  // of vertical blanking so the whole next active area sees one mode).
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      frame_cnt  <= 16'd0;
      mode_frame <= '0;
    end else begin
      if (advance && h_last && v_last) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (advance && h_last && (v_cnt == C_V_ACT_LAST)) begin
        mode_frame <= mode_in;
      end
    end
  end

endmodule
`default_nettype wire
